elink_frame_writer: RTL

Downlink-side e-link frame transmitter for the MOPS-Hub core. Accepts one 76-bit CAN-derived message from the core's receive path (`data_rec_uplink`), handshakes it with `send_mes_elink` / `start_write_elink` / `end_write_elink`, and emits it as a byte-framed stream (SOP, padded payload, optional CRC, EOP) toward the e-link encoder. It is the write-direction counterpart of the uplink frame reader that feeds `data_tra_uplink` into the core.

---
 rtl/mopshub_elink_pkg.sv | 29 ++
 rtl/elink_crc8.sv | 28 ++
 rtl/elink_frame_writer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/mopshub_elink_pkg.sv
// ============================================================================
// Module : mopshub_elink_pkg
// Brief  : Shared types and constants for the MOPS-Hub e-link frame path.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mopshub_elink_pkg;

    localparam logic [7:0] C_SOP_CHAR_DEF = 8'h3C;  // K28.1
    localparam logic [7:0] C_EOP_CHAR_DEF = 8'hDC;  // K28.6
    localparam logic [7:0] CRC8_POLY      = 8'h07;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SOP     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CRC     = 3'd3,
        ST_EOP     = 3'd4,
        ST_DONE    = 3'd5
    } elink_wr_state_t;

    function automatic int calc_nbytes(input int width);
        return (width + 7) / 8;
    endfunction

endpackage

`default_nettype wire

// File: rtl/elink_crc8.sv
// ============================================================================
// Module : elink_crc8
// Brief  : Combinational CRC-8 byte update (poly 0x07, MSB first, no reflect).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module elink_crc8
    import mopshub_elink_pkg::*;
(
    input  logic [7:0] i_crc,
    input  logic [7:0] i_byte,
    output logic [7:0] o_crc_next
);

    logic [7:0] w_crc;

    always_comb begin
        w_crc = i_crc ^ i_byte;
        for (int i = 0; i < 8; i++) begin
            w_crc = w_crc[7] ? ((w_crc << 1) ^ CRC8_POLY) : (w_crc << 1);
        end
        o_crc_next = w_crc;
    end

endmodule

`default_nettype wire

// File: rtl/elink_frame_writer.sv
// ============================================================================
// Module : elink_frame_writer
// Brief  : Frames one core message as SOP / payload / [CRC-8] / EOP bytes.
//          Optional CRC byte enabled by defining ELINK_WRITER_CRC_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module elink_frame_writer
    import mopshub_elink_pkg::*;
#(
    parameter int         PAYLOAD_W = 76,
    parameter logic [7:0] SOP_CHAR  = C_SOP_CHAR_DEF,
    parameter logic [7:0] EOP_CHAR  = C_EOP_CHAR_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PAYLOAD_W-1:0] data_rec_uplink,
    input  logic                 send_mes_elink,
    output logic                 start_write_elink,
    output logic                 end_write_elink,
    output logic                 busy,
    output logic [7:0]           tx_data,
    output logic                 tx_k,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [15:0]          frame_cnt
);

    localparam int         NBYTES     = calc_nbytes(PAYLOAD_W);
    localparam int         SHIFT_W    = 8 * NBYTES;
    localparam logic [3:0] C_LAST_IDX = 4'(NBYTES - 1);

    elink_wr_state_t    r_state;
    elink_wr_state_t    w_state_nxt;
    logic [SHIFT_W-1:0] r_shift;
    logic [SHIFT_W-1:0] w_shift_nxt;
    logic [SHIFT_W-1:0] w_pad;
    logic [3:0]         r_idx;
    logic [3:0]         w_idx_nxt;
    logic [7:0]         r_tx_data;
    logic [7:0]         w_tx_data_nxt;
    logic               r_tx_k;
    logic               w_tx_k_nxt;
    logic               r_tx_valid;
    logic               w_tx_valid_nxt;
    logic               r_start;
    logic               r_end;
    logic               r_busy;
    logic               w_busy_nxt;
    logic [15:0]        r_frame_cnt;
    logic               w_acc;
    logic               w_capture;
    logic               w_pay_acc;
    logic               w_last;

    assign w_acc     = r_tx_valid & tx_ready;
    assign w_capture = (r_state == ST_IDLE) & send_mes_elink;
    assign w_pay_acc = (r_state == ST_PAYLOAD) & w_acc;
    assign w_last    = (r_idx == C_LAST_IDX);

    always_comb begin
        w_pad                  = '0;
        w_pad[PAYLOAD_W-1:0]   = data_rec_uplink;
    end

`ifdef ELINK_WRITER_CRC_EN
    logic [7:0] r_crc;
    logic [7:0] w_crc_upd;
    logic [7:0] w_crc_nxt;

    // The byte on the bus is the one being accepted, so it feeds the CRC.
    elink_crc8 u_crc8 (
        .i_crc      (r_crc),
        .i_byte     (r_tx_data),
        .o_crc_next (w_crc_upd)
    );

    always_comb begin
        w_crc_nxt = r_crc;
        if (w_capture) begin
            w_crc_nxt = 8'h00;
        end else if (w_pay_acc) begin
            w_crc_nxt = w_crc_upd;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_crc <= 8'h00;
        end else begin
            r_crc <= w_crc_nxt;
        end
    end
`endif

    always_comb begin
        w_shift_nxt = r_shift;
        w_idx_nxt   = r_idx;
        if (w_capture) begin
            w_shift_nxt = w_pad;
            w_idx_nxt   = 4'd0;
        end else if (w_pay_acc) begin
            w_shift_nxt = r_shift << 8;
            w_idx_nxt   = r_idx + 4'd1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (send_mes_elink) w_state_nxt = ST_SOP;
            ST_SOP:     if (w_acc) w_state_nxt = ST_PAYLOAD;
`ifdef ELINK_WRITER_CRC_EN
            ST_PAYLOAD: if (w_acc && w_last) w_state_nxt = ST_CRC;
            ST_CRC:     if (w_acc) w_state_nxt = ST_EOP;
`else
            ST_PAYLOAD: if (w_acc && w_last) w_state_nxt = ST_EOP;
`endif
            ST_EOP:     if (w_acc) w_state_nxt = ST_DONE;
            ST_DONE:    w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Output logic: derived from the next state so the registered byte
    // appears together with the state that owns it and holds while stalled.
    always_comb begin
        w_tx_valid_nxt = 1'b0;
        w_tx_k_nxt     = 1'b0;
        w_tx_data_nxt  = 8'h00;
        case (w_state_nxt)
            ST_SOP: begin
                w_tx_valid_nxt = 1'b1;
                w_tx_k_nxt     = 1'b1;
                w_tx_data_nxt  = SOP_CHAR;
            end
            ST_PAYLOAD: begin
                w_tx_valid_nxt = 1'b1;
                w_tx_data_nxt  = w_shift_nxt[SHIFT_W-1 -: 8];
            end
`ifdef ELINK_WRITER_CRC_EN
            ST_CRC: begin
                w_tx_valid_nxt = 1'b1;
                w_tx_data_nxt  = w_crc_nxt;
            end
`endif
            ST_EOP: begin
                w_tx_valid_nxt = 1'b1;
                w_tx_k_nxt     = 1'b1;
                w_tx_data_nxt  = EOP_CHAR;
            end
            default: begin
                w_tx_valid_nxt = 1'b0;
            end
        endcase
        // DONE extends busy over the end_write_elink cycle that follows it.
        w_busy_nxt = (w_state_nxt != ST_IDLE) || (r_state == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift     <= '0;
            r_idx       <= 4'd0;
            r_tx_data   <= 8'h00;
            r_tx_k      <= 1'b0;
            r_tx_valid  <= 1'b0;
            r_start     <= 1'b0;
            r_end       <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_cnt <= 16'd0;
        end else begin
            r_shift    <= w_shift_nxt;
            r_idx      <= w_idx_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_tx_k     <= w_tx_k_nxt;
            r_tx_valid <= w_tx_valid_nxt;
            r_start    <= w_capture;
            r_end      <= (r_state == ST_DONE);
            r_busy     <= w_busy_nxt;
            if (r_state == ST_DONE) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    assign start_write_elink = r_start;
    assign end_write_elink   = r_end;
    assign busy              = r_busy;
    assign tx_data           = r_tx_data;
    assign tx_k              = r_tx_k;
    assign tx_valid          = r_tx_valid;
    assign frame_cnt         = r_frame_cnt;

endmodule

`default_nettype wire
